// File: rtl/spi_xfer_ctrl.sv
// Purpose: sequences 1..256-byte SPI transactions around a single-byte SPI master engine.
// Latency: ss asserts 1 cycle after accept, first start SETUP_CYC cycles later, RX byte valid 1 cycle after done tick.
// Backpressure: a pending RX byte blocks the next byte start; TX starvation parks in LOAD with ss held low.
module spi_xfer_ctrl #(
    parameter int NUM_SS    = 4,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 4,
    localparam int SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [7:0]        cmd_len_i,
    input  logic [SS_W-1:0]   cmd_ss_i,
    input  logic              cmd_cpol_i,
    input  logic              cmd_cpha_i,
    input  logic [15:0]       cmd_dvsr_i,
    input  logic              abort_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [7:0]        tx_data_i,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic [7:0]        rx_data_o,
    output logic              busy_o,
    output logic              xfer_done_o,
    output logic              aborted_o,
    output logic [NUM_SS-1:0] ss_n_o,
    output logic              spi_start_o,
    output logic [7:0]        spi_din_o,
    output logic [15:0]       spi_dvsr_o,
    output logic              spi_cpol_o,
    output logic              spi_cpha_o,
    input  logic              spi_ready_i,
    input  logic              spi_done_tick_i,
    input  logic [7:0]        spi_dout_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_XFER,
        S_RXWAIT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_remain;
    logic              r_abort;
    logic              r_cpol;
    logic              r_cpha;
    logic [15:0]       r_dvsr;
    logic [NUM_SS-1:0] r_ss_n;
    logic [7:0]        r_din;
    logic [7:0]        r_rx_data;
    logic              r_rx_vld;
    logic              r_done;

    state_t            w_next;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_start;
    logic              w_accept;
    logic              w_rx_free;
    logic              w_byte_done;
    logic              w_dec_remain;
    logic              w_ss_off;
    logic              w_done_set;
    logic              w_abort_win;
    logic [NUM_SS-1:0] w_ss_dec;

    // Next-state, delay counter and strobes; abort wins over a same-cycle start.
    always_comb begin
        w_next       = r_state;
        w_cnt_nxt    = r_cnt;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_dec_remain = 1'b0;
        w_ss_off     = 1'b0;
        w_done_set   = 1'b0;
        w_abort_win  = 1'b0;
        w_rx_free    = !r_rx_vld || rx_ready_i;
        w_byte_done  = (r_state == S_XFER) && spi_done_tick_i;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_accept  = 1'b1;
                    w_next    = S_SETUP;
                    w_cnt_nxt = SETUP_LD;
                end
            end
            S_SETUP: begin
                w_abort_win = 1'b1;
                if (abort_i) begin
                    w_next    = S_HOLD;
                    w_cnt_nxt = HOLD_LD;
                end else if (r_cnt == '0) begin
                    w_next = S_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_LOAD: begin
                w_abort_win = 1'b1;
                if (abort_i) begin
                    w_next    = S_HOLD;
                    w_cnt_nxt = HOLD_LD;
                end else if (tx_valid_i && spi_ready_i && w_rx_free) begin
                    w_start = 1'b1;
                    w_next  = S_XFER;
                end
            end
            S_XFER: begin
                w_abort_win = 1'b1;
                if (spi_done_tick_i) begin
                    if (r_remain == 8'd0 || r_abort || abort_i) begin
                        w_next    = S_HOLD;
                        w_cnt_nxt = HOLD_LD;
                    end else begin
                        w_dec_remain = 1'b1;
                        w_next       = S_RXWAIT;
                    end
                end
            end
            S_RXWAIT: begin
                w_abort_win = 1'b1;
                if (abort_i) begin
                    w_next    = S_HOLD;
                    w_cnt_nxt = HOLD_LD;
                end else if (w_rx_free) begin
                    w_next = S_LOAD;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_ss_off  = 1'b1;
                    w_next    = S_GAP;
                    w_cnt_nxt = GAP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_done_set = 1'b1;
                    w_next     = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Slave-select decode; an out-of-range index selects nothing.
    always_comb begin
        w_ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (int'(cmd_ss_i) == i) begin
                w_ss_dec[i] = 1'b0;
            end
        end
    end

    // State register and shared setup/hold/gap delay counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Per-transaction mode, byte count and abort flag, held until the next accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_remain <= '0;
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            r_dvsr   <= '0;
            r_abort  <= 1'b0;
        end else if (w_accept) begin
            r_remain <= cmd_len_i;
            r_cpol   <= cmd_cpol_i;
            r_cpha   <= cmd_cpha_i;
            r_dvsr   <= cmd_dvsr_i;
            r_abort  <= 1'b0;
        end else begin
            if (w_dec_remain) begin
                r_remain <= r_remain - 8'd1;
            end
            if (w_abort_win && abort_i) begin
                r_abort <= 1'b1;
            end
        end
    end

    // Chip selects: drive the decoded line on accept, release all when hold expires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ss_n <= '1;
        end else if (w_accept) begin
            r_ss_n <= w_ss_dec;
        end else if (w_ss_off) begin
            r_ss_n <= '1;
        end
    end

    // Keep a copy of the TX byte handed to the engine.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_din <= '0;
        end else if (w_start) begin
            r_din <= tx_data_i;
        end
    end

    // Single-entry RX holding register; a new byte can only land after the slot was freed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_data <= '0;
            r_rx_vld  <= 1'b0;
        end else if (w_byte_done) begin
            r_rx_data <= spi_dout_i;
            r_rx_vld  <= 1'b1;
        end else if (rx_ready_i) begin
            r_rx_vld <= 1'b0;
        end
    end

    // Completion pulse on the first IDLE cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
        end
    end

    assign cmd_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign tx_ready_o  = w_start;
    assign spi_start_o = w_start;
    assign spi_din_o   = w_start ? tx_data_i : r_din;
    assign spi_dvsr_o  = r_dvsr;
    assign spi_cpol_o  = r_cpol;
    assign spi_cpha_o  = r_cpha;
    assign ss_n_o      = r_ss_n;
    assign rx_valid_o  = r_rx_vld;
    assign rx_data_o   = r_rx_data;
    assign xfer_done_o = r_done;
    assign aborted_o   = r_done && r_abort;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: loopback engine model, TX feeder, RX scoreboard.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
// Table of transactions plus hand-written stall, starvation, abort, back-to-back, long-burst and reset sequences.
module tb_spi_xfer_ctrl;

    localparam int NUM_SS    = 4;
    localparam int SETUP_CYC = 2;
    localparam int HOLD_CYC  = 2;
    localparam int GAP_CYC   = 4;
    localparam int ENG_CYC   = 3;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [7:0]        cmd_len_i = '0;
    logic [1:0]        cmd_ss_i = '0;
    logic              cmd_cpol_i = 1'b0;
    logic              cmd_cpha_i = 1'b0;
    logic [15:0]       cmd_dvsr_i = '0;
    logic              abort_i = 1'b0;
    logic              tx_valid_i = 1'b0;
    logic              tx_ready_o;
    logic [7:0]        tx_data_i = '0;
    logic              rx_valid_o;
    logic              rx_ready_i = 1'b1;
    logic [7:0]        rx_data_o;
    logic              busy_o;
    logic              xfer_done_o;
    logic              aborted_o;
    logic [NUM_SS-1:0] ss_n_o;
    logic              spi_start_o;
    logic [7:0]        spi_din_o;
    logic [15:0]       spi_dvsr_o;
    logic              spi_cpol_o;
    logic              spi_cpha_o;
    logic              spi_ready_i = 1'b1;
    logic              spi_done_tick_i = 1'b0;
    logic [7:0]        spi_dout_i = '0;

    always #5 clk_i = ~clk_i;

    spi_xfer_ctrl #(
        .NUM_SS(NUM_SS), .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
        .cmd_ss_i(cmd_ss_i), .cmd_cpol_i(cmd_cpol_i), .cmd_cpha_i(cmd_cpha_i),
        .cmd_dvsr_i(cmd_dvsr_i), .abort_i(abort_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
        .busy_o(busy_o), .xfer_done_o(xfer_done_o), .aborted_o(aborted_o), .ss_n_o(ss_n_o),
        .spi_start_o(spi_start_o), .spi_din_o(spi_din_o), .spi_dvsr_o(spi_dvsr_o),
        .spi_cpol_o(spi_cpol_o), .spi_cpha_o(spi_cpha_o), .spi_ready_i(spi_ready_i),
        .spi_done_tick_i(spi_done_tick_i), .spi_dout_i(spi_dout_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Shared bench state
    logic [7:0]        sb_q[$];
    logic [7:0]        tx_q[$];
    bit                tx_en = 1'b0;
    bit                tx_hs = 1'b0;
    int                cyc = 0;
    int                n_start = 0;
    int                n_done = 0;
    int                n_acc = 0;
    int                n_rx = 0;
    int                ss_low_cyc = 0;
    int                ss_fall = 0;
    int                rise_cyc = 0;
    int                acc_cyc = 0;
    logic [NUM_SS-1:0] prev_ss = '1;

    // Monitor: event counters, TX->expected RX push, RX pop/compare, invariants.
    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) begin
            prev_ss = '1;
        end else begin
            cyc++;
            if (spi_start_o) n_start++;
            if (xfer_done_o) n_done++;
            if (cmd_valid_i && cmd_ready_o) begin
                n_acc++;
                acc_cyc = cyc;
            end
            if (ss_n_o != '1) ss_low_cyc++;
            if (prev_ss == '1 && ss_n_o != '1) ss_fall++;
            if (prev_ss != '1 && ss_n_o == '1) rise_cyc = cyc;
            prev_ss = ss_n_o;
            check("ss_single_low", 32'($countones(~ss_n_o) > 1), 32'(0));
            check("start_eq_txrdy", 32'(spi_start_o), 32'(tx_ready_o));
            if (tx_valid_i && tx_ready_o) begin
                sb_q.push_back(tx_data_i);
                tx_hs = 1'b1;
            end
            if (rx_valid_o && rx_ready_i) begin
                n_rx++;
                if (sb_q.size() == 0) check("rx_unexpected", 32'(rx_data_o), 32'hFFFF_FFFF);
                else check("rx_data", 32'(rx_data_o), 32'(sb_q.pop_front()));
            end
        end
    end

    // TX feeder: presents the head of tx_q while enabled.
    initial forever begin
        step();
        if (tx_hs) begin
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            tx_hs = 1'b0;
        end
        tx_valid_i = tx_en && (tx_q.size() > 0);
        tx_data_i  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end

    // Loopback engine: busy ENG_CYC cycles after a start, then a done tick echoing the TX byte.
    initial begin : engine
        logic       st;
        logic [7:0] d;
        logic [7:0] data;
        int         cnt;
        cnt = 0;
        data = '0;
        forever begin
            @(negedge clk_i);
            st = spi_start_o;
            d  = spi_din_o;
            step();
            if (!rst_ni) begin
                spi_ready_i = 1'b1;
                spi_done_tick_i = 1'b0;
                cnt = 0;
            end else begin
                if (spi_done_tick_i) begin
                    spi_done_tick_i = 1'b0;
                    spi_ready_i = 1'b1;
                end
                if (st) begin
                    spi_ready_i = 1'b0;
                    cnt = ENG_CYC;
                    data = d;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        spi_done_tick_i = 1'b1;
                        spi_dout_i = data;
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [7:0] len, input logic [1:0] ss, input logic cpol,
                            input logic cpha, input logic [15:0] dvsr);
        int base = n_acc;
        cmd_len_i = len; cmd_ss_i = ss; cmd_cpol_i = cpol; cmd_cpha_i = cpha; cmd_dvsr_i = dvsr;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 200 && n_acc == base; i++) step();
        cmd_valid_i = 1'b0;
        check("cmd_accept", 32'(n_acc - base), 32'(1));
    endtask

    task automatic wait_done(input logic exp_ab, input string tag);
        logic seen = 1'b0;
        logic ab = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk_i);
            if (xfer_done_o) begin
                seen = 1'b1;
                ab = aborted_o;
            end
        end
        check({tag, "_done"}, 32'(seen), 32'(1));
        check({tag, "_aborted"}, 32'(ab), 32'(exp_ab));
        step();
    endtask

    task automatic load_tx(input int n);
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    endtask

    typedef struct {
        logic [7:0]  len;
        logic [1:0]  ss;
        logic        cpol;
        logic        cpha;
        logic [15:0] dvsr;
        logic [3:0]  exp_ss_n;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int b_start, b_rx, b_low, b_fall, b_done, b_acc, bad, rdy_cnt;
        vecs[0] = '{len: 8'd0, ss: 2'd1, cpol: 1'b0, cpha: 1'b0, dvsr: 16'd3,     exp_ss_n: 4'b1101};
        vecs[1] = '{len: 8'd2, ss: 2'd0, cpol: 1'b1, cpha: 1'b0, dvsr: 16'h0010, exp_ss_n: 4'b1110};
        vecs[2] = '{len: 8'd1, ss: 2'd2, cpol: 1'b0, cpha: 1'b1, dvsr: 16'hBEEF, exp_ss_n: 4'b1011};
        vecs[3] = '{len: 8'd5, ss: 2'd3, cpol: 1'b1, cpha: 1'b1, dvsr: 16'hFFFF, exp_ss_n: 4'b0111};

        // Reset values
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ss_n", 32'(ss_n_o), 32'(4'hF));
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'(1));
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_start", 32'(spi_start_o), 32'(0));
        check("rst_tx_ready", 32'(tx_ready_o), 32'(0));
        check("rst_rx_valid", 32'(rx_valid_o), 32'(0));
        check("rst_done", 32'(xfer_done_o), 32'(0));
        check("rst_aborted", 32'(aborted_o), 32'(0));
        check("rst_rx_data", 32'(rx_data_o), 32'(0));
        check("rst_din", 32'(spi_din_o), 32'(0));
        check("rst_dvsr", 32'(spi_dvsr_o), 32'(0));
        check("rst_mode", 32'({spi_cpol_o, spi_cpha_o}), 32'(0));
        step();
        rst_ni = 1'b1;
        step();

        // Table-driven transactions with free-flowing TX and RX
        foreach (vecs[k]) begin
            if (k == 0) tx_q.push_back(8'hA5);
            else load_tx(int'(vecs[k].len) + 1);
            tx_en = 1'b1;
            b_start = n_start; b_rx = n_rx; b_low = ss_low_cyc; b_fall = ss_fall;
            send_cmd(vecs[k].len, vecs[k].ss, vecs[k].cpol, vecs[k].cpha, vecs[k].dvsr);
            @(negedge clk_i);
            check("vec_ss_n", 32'(ss_n_o), 32'(vecs[k].exp_ss_n));
            check("vec_dvsr", 32'(spi_dvsr_o), 32'(vecs[k].dvsr));
            check("vec_mode", 32'({spi_cpol_o, spi_cpha_o}), 32'({vecs[k].cpol, vecs[k].cpha}));
            check("vec_busy", 32'(busy_o), 32'(1));
            wait_done(1'b0, "vec");
            check("vec_starts", 32'(n_start - b_start), 32'(vecs[k].len) + 32'(1));
            check("vec_rx_count", 32'(n_rx - b_rx), 32'(vecs[k].len) + 32'(1));
            check("vec_ss_low_cycles", 32'(ss_low_cyc - b_low),
                  32'(SETUP_CYC + HOLD_CYC + (int'(vecs[k].len) + 1) * (ENG_CYC + 2) + int'(vecs[k].len)));
            check("vec_ss_pulses", 32'(ss_fall - b_fall), 32'(1));
            check("vec_sb_empty", 32'(sb_q.size()), 32'(0));
            check("vec_dvsr_held", 32'(spi_dvsr_o), 32'(vecs[k].dvsr));
        end
        check("first_rx_byte", 32'(rx_data_o) & 32'h0, 32'(0));

        // RX backpressure after byte 2 of a 4-byte burst
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        b_start = n_start; b_rx = n_rx; b_fall = ss_fall;
        send_cmd(8'd3, 2'd2, 1'b1, 1'b1, 16'd7);
        for (int i = 0; i < 500 && (n_rx - b_rx) < 2; i++) step();
        rx_ready_i = 1'b0;
        repeat (20) step();
        check("stall_starts", 32'(n_start - b_start), 32'(3));
        check("stall_rx_valid", 32'(rx_valid_o), 32'(1));
        check("stall_rx_data", 32'(rx_data_o), 32'(8'h03));
        check("stall_ss_n", 32'(ss_n_o), 32'(4'b1011));
        check("stall_mode", 32'({spi_cpol_o, spi_cpha_o}), 32'(2'b11));
        rx_ready_i = 1'b1;
        wait_done(1'b0, "stall");
        check("stall_total_starts", 32'(n_start - b_start), 32'(4));
        check("stall_rx_count", 32'(n_rx - b_rx), 32'(4));
        check("stall_ss_pulses", 32'(ss_fall - b_fall), 32'(1));

        // TX starvation parks in LOAD with ss asserted
        tx_en = 1'b0;
        tx_q.push_back(8'h3C);
        b_start = n_start;
        send_cmd(8'd0, 2'd0, 1'b0, 1'b0, 16'd2);
        bad = 0;
        repeat (50) begin
            @(negedge clk_i);
            if (tx_ready_o || spi_start_o || ss_n_o != 4'b1110) bad++;
        end
        check("starve_idle_engine", 32'(bad), 32'(0));
        check("starve_no_start", 32'(n_start - b_start), 32'(0));
        step();
        tx_en = 1'b1;
        wait_done(1'b0, "starve");
        check("starve_starts", 32'(n_start - b_start), 32'(1));

        // Abort during byte 2 of an 8-byte burst
        load_tx(8);
        b_start = n_start; b_rx = n_rx;
        send_cmd(8'd7, 2'd3, 1'b0, 1'b0, 16'd5);
        for (int i = 0; i < 500 && (n_start - b_start) < 2; i++) step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        wait_done(1'b1, "abort");
        check("abort_starts", 32'(n_start - b_start), 32'(2));
        check("abort_rx_count", 32'(n_rx - b_rx), 32'(2));
        check("abort_sb_empty", 32'(sb_q.size()), 32'(0));
        tx_en = 1'b0;
        step();
        tx_q.delete();
        tx_en = 1'b1;

        // Back-to-back commands with cmd_valid_i held high
        load_tx(2);
        b_acc = n_acc; b_done = n_done;
        rdy_cnt = 0;
        cmd_len_i = 8'd0; cmd_ss_i = 2'd1; cmd_cpol_i = 1'b0; cmd_cpha_i = 1'b1; cmd_dvsr_i = 16'd9;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 1000 && n_acc < b_acc + 2; i++) begin
            if (n_acc == b_acc + 1 && cmd_ready_o) rdy_cnt++;
            step();
        end
        cmd_valid_i = 1'b0;
        check("b2b_accepts", 32'(n_acc - b_acc), 32'(2));
        check("b2b_gap", 32'(acc_cyc - rise_cyc), 32'(GAP_CYC));
        check("b2b_ready_cycles", 32'(rdy_cnt), 32'(1));
        wait_done(1'b0, "b2b");
        check("b2b_dones", 32'(n_done - b_done), 32'(2));

        // 256-byte burst
        load_tx(256);
        b_start = n_start; b_rx = n_rx; b_done = n_done;
        send_cmd(8'd255, 2'd0, 1'b1, 1'b0, 16'h1234);
        wait_done(1'b0, "burst");
        repeat (GAP_CYC + 2) step();
        check("burst_starts", 32'(n_start - b_start), 32'(256));
        check("burst_rx_count", 32'(n_rx - b_rx), 32'(256));
        check("burst_single_done", 32'(n_done - b_done), 32'(1));
        check("burst_sb_empty", 32'(sb_q.size()), 32'(0));

        // Reset in the middle of a long burst
        load_tx(256);
        b_start = n_start;
        send_cmd(8'd255, 2'd2, 1'b1, 1'b1, 16'hABCD);
        for (int i = 0; i < 5000 && (n_start - b_start) < 100; i++) step();
        rst_ni = 1'b0;
        #2;
        check("mrst_ss_n", 32'(ss_n_o), 32'(4'hF));
        check("mrst_busy", 32'(busy_o), 32'(0));
        check("mrst_cmd_ready", 32'(cmd_ready_o), 32'(1));
        check("mrst_start", 32'(spi_start_o), 32'(0));
        check("mrst_tx_ready", 32'(tx_ready_o), 32'(0));
        check("mrst_rx_valid", 32'(rx_valid_o), 32'(0));
        check("mrst_rx_data", 32'(rx_data_o), 32'(0));
        check("mrst_din", 32'(spi_din_o), 32'(0));
        check("mrst_dvsr", 32'(spi_dvsr_o), 32'(0));
        check("mrst_mode", 32'({spi_cpol_o, spi_cpha_o}), 32'(0));
        check("mrst_done", 32'({xfer_done_o, aborted_o}), 32'(0));
        tx_en = 1'b0;
        tx_q.delete();
        sb_q.delete();
        tx_hs = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
        @(negedge clk_i);
        check("post_rst_ss_n", 32'(ss_n_o), 32'(4'hF));
        check("post_rst_cmd_ready", 32'(cmd_ready_o), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
